xor_memory: RTL and testbench

XOR_MEMORY -- requirements
Module: xor_memory

---
 rtl/xor_memory.sv | 89 ++++++++
 tb/tb_xor_memory.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/xor_memory.sv
// Multi-port memory built from one flop bank per port, where the logical word is the XOR of all banks.
// Define XOR_MEMORY_BYPASS_EN to make reads of a word written in the same cycle return the new data.
module xor_memory #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256,
    parameter int PORTS = 2,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic [AW-1:0]    addr [PORTS],
    input  logic [WIDTH-1:0] d    [PORTS],
    input  logic             en   [PORTS],
    output logic [WIDTH-1:0] q    [PORTS],
    input  logic             rst_n
);

    logic [WIDTH-1:0] bank     [PORTS][DEPTH];
    logic             in_range [PORTS];
    logic [WIDTH-1:0] rd_word  [PORTS];
    logic [WIDTH-1:0] wr_data  [PORTS];
    logic             wr_win   [PORTS];
    logic [WIDTH-1:0] next_q   [PORTS];

    // Port i stores d XOR the other banks so the XOR of all banks becomes d;
    // on a same-address collision only the lowest-numbered port is allowed to write.
    always_comb begin
        for (int p = 0; p < PORTS; p++) begin
            in_range[p] = (int'(addr[p]) < DEPTH);
        end
        for (int p = 0; p < PORTS; p++) begin
            rd_word[p] = '0;
            if (in_range[p]) begin
                for (int b = 0; b < PORTS; b++) begin
                    rd_word[p] = rd_word[p] ^ bank[b][addr[p]];
                end
            end
            wr_data[p] = '0;
            if (in_range[p]) begin
                wr_data[p] = d[p] ^ rd_word[p] ^ bank[p][addr[p]];
            end
            wr_win[p] = en[p] && in_range[p];
            for (int k = 0; k < p; k++) begin
                if (en[k] && in_range[k] && (addr[k] == addr[p])) begin
                    wr_win[p] = 1'b0;
                end
            end
            next_q[p] = rd_word[p];
        end
`ifdef XOR_MEMORY_BYPASS_EN
        // Scan from the top down so the lowest-numbered writer is the one left in next_q.
        for (int p = 0; p < PORTS; p++) begin
            for (int k = PORTS - 1; k >= 0; k--) begin
                if (en[k] && in_range[k] && (addr[k] == addr[p])) begin
                    next_q[p] = d[k];
                end
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < PORTS; p++) begin
                for (int a = 0; a < DEPTH; a++) begin
                    bank[p][a] <= '0;
                end
            end
        end else begin
            for (int p = 0; p < PORTS; p++) begin
                if (wr_win[p]) begin
                    bank[p][addr[p]] <= wr_data[p];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < PORTS; p++) begin
                q[p] <= '0;
            end
        end else begin
            for (int p = 0; p < PORTS; p++) begin
                q[p] <= next_q[p];
            end
        end
    end

endmodule

// File: tb/tb_xor_memory.sv
// Directed self-checking bench for xor_memory with two ports, 8-bit words and 256 entries.
// Expected values are hand-computed; same-cycle reads follow XOR_MEMORY_BYPASS_EN when defined.
module tb_xor_memory;

    logic       clk;
    logic       rst_n;
    logic [7:0] addr [2];
    logic [7:0] d    [2];
    logic       en   [2];
    logic [7:0] q    [2];

    int check_count;
    int error_count;

    xor_memory #(.WIDTH(8), .DEPTH(256), .PORTS(2)) dut (
        .clk   (clk),
        .addr  (addr),
        .d     (d),
        .en    (en),
        .q     (q),
        .rst_n (rst_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation timeout");
    end

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of port inputs, then return 1 time unit after the capturing edge.
    task automatic applyStimulus(input logic [7:0] a0, input logic [7:0] d0, input logic e0,
                                 input logic [7:0] a1, input logic [7:0] d1, input logic e1);
        addr[0] = a0; d[0] = d0; en[0] = e0;
        addr[1] = a1; d[1] = d1; en[1] = e1;
        @(posedge clk);
        #1;
        en[0] = 1'b0;
        en[1] = 1'b0;
    endtask

    initial begin
        check_count = 0;
        error_count = 0;
        rst_n = 1'b0;
        for (int p = 0; p < 2; p++) begin
            addr[p] = '0; d[p] = '0; en[p] = 1'b0;
        end
        #3;
        checkOutput("reset_q0", q[0], 8'h00);
        checkOutput("reset_q1", q[1], 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(8'h00, 8'h00, 1'b0, 8'hFF, 8'h00, 1'b0);
        checkOutput("post_reset_q0_00", q[0], 8'h00);
        checkOutput("post_reset_q1_ff", q[1], 8'h00);

        applyStimulus(8'h10, 8'hA5, 1'b1, 8'h10, 8'h00, 1'b0);
`ifdef XOR_MEMORY_BYPASS_EN
        checkOutput("wr10_same_cycle_q1", q[1], 8'hA5);
`else
        checkOutput("wr10_same_cycle_q1", q[1], 8'h00);
`endif
        applyStimulus(8'h00, 8'h00, 1'b0, 8'h10, 8'h00, 1'b0);
        checkOutput("rd10_q1", q[1], 8'hA5);

        applyStimulus(8'h01, 8'h3C, 1'b1, 8'h02, 8'hC3, 1'b1);
        applyStimulus(8'h02, 8'h00, 1'b0, 8'h01, 8'h00, 1'b0);
        checkOutput("rd02_q0", q[0], 8'hC3);
        checkOutput("rd01_q1", q[1], 8'h3C);

        applyStimulus(8'h40, 8'h11, 1'b1, 8'h40, 8'h22, 1'b1);
`ifdef XOR_MEMORY_BYPASS_EN
        checkOutput("collide40_same_q1", q[1], 8'h11);
`else
        checkOutput("collide40_same_q1", q[1], 8'h00);
`endif
        applyStimulus(8'h40, 8'h00, 1'b0, 8'h40, 8'h00, 1'b0);
        checkOutput("collide40_q0", q[0], 8'h11);
        checkOutput("collide40_q1", q[1], 8'h11);

        applyStimulus(8'h20, 8'h55, 1'b1, 8'h00, 8'h00, 1'b0);
        applyStimulus(8'h20, 8'h00, 1'b0, 8'h20, 8'h66, 1'b1);
`ifdef XOR_MEMORY_BYPASS_EN
        checkOutput("overwrite20_same_q0", q[0], 8'h66);
        checkOutput("overwrite20_same_q1", q[1], 8'h66);
`else
        checkOutput("overwrite20_same_q0", q[0], 8'h55);
        checkOutput("overwrite20_same_q1", q[1], 8'h55);
`endif
        applyStimulus(8'h20, 8'h00, 1'b0, 8'h20, 8'h00, 1'b0);
        checkOutput("overwrite20_q0", q[0], 8'h66);
        checkOutput("overwrite20_q1", q[1], 8'h66);

        // Port 1 overwrites a word whose bank-0 copy is non-zero, then port 0 writes again.
        applyStimulus(8'h00, 8'h00, 1'b0, 8'h10, 8'h0F, 1'b1);
        applyStimulus(8'h10, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);
        checkOutput("xor10_p1_q0", q[0], 8'h0F);
        applyStimulus(8'h10, 8'hF0, 1'b1, 8'h20, 8'h00, 1'b0);
        applyStimulus(8'h00, 8'h00, 1'b0, 8'h10, 8'h00, 1'b0);
        checkOutput("xor10_p0_q1", q[1], 8'hF0);

        for (int i = 0; i < 5; i++) applyStimulus(8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);
        applyStimulus(8'h02, 8'h00, 1'b0, 8'h20, 8'h00, 1'b0);
        checkOutput("idle_hold02", q[0], 8'hC3);
        checkOutput("idle_hold20", q[1], 8'h66);

        applyStimulus(8'h05, 8'h77, 1'b1, 8'h00, 8'h00, 1'b0);
        applyStimulus(8'h05, 8'h00, 1'b0, 8'h05, 8'h00, 1'b0);
        checkOutput("rd05_q0", q[0], 8'h77);
        checkOutput("rd05_q1", q[1], 8'h77);

        addr[0] = 8'h05; d[0] = 8'h99; en[0] = 1'b1;
        addr[1] = 8'h06; d[1] = 8'h12; en[1] = 1'b1;
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("async_clear_q0", q[0], 8'h00);
        checkOutput("async_clear_q1", q[1], 8'h00);
        @(posedge clk);
        #1;
        checkOutput("in_reset_q0", q[0], 8'h00);
        en[0] = 1'b0;
        en[1] = 1'b0;
        #2;
        rst_n = 1'b1;

        applyStimulus(8'h05, 8'h00, 1'b0, 8'h06, 8'h00, 1'b0);
        checkOutput("after_reset_rd05", q[0], 8'h00);
        checkOutput("after_reset_rd06", q[1], 8'h00);
        applyStimulus(8'h10, 8'h00, 1'b0, 8'h20, 8'h00, 1'b0);
        checkOutput("after_reset_rd10", q[0], 8'h00);
        checkOutput("after_reset_rd20", q[1], 8'h00);

        applyStimulus(8'h05, 8'hAA, 1'b1, 8'h00, 8'h00, 1'b0);
        applyStimulus(8'h00, 8'h00, 1'b0, 8'h05, 8'h00, 1'b0);
        checkOutput("first_write_after_reset", q[1], 8'hAA);

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule
